tinker_fetch_queue: RTL

- Instruction-fetch front end for the dual-issue tinker pipeline.
- Generates 8-byte-aligned fetch requests to instruction memory and buffers returned instruction pairs in an in-order queue.
- Presents one {pc, instr0, instr1} bundle per cycle to the IF/ID stage under a valid/ready handshake.
- Handles branch redirects: flushes buffered and in-flight fetches, then restarts at the new target.

---
 rtl/tinker_fetch_queue_if.sv | 30 +++
 rtl/tinker_fetch_queue.sv | 134 +++++++++++++
 2 files changed

// File: rtl/tinker_fetch_queue_if.sv
// Fetch-queue bus bundle: memory request/response, decode-side output and branch redirect/halt.
// The master modport is the fetch queue itself; the slave modport is its environment.
interface tinker_fetch_queue_if;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic        rsp_valid;
   logic [31:0] rsp_instr0;
   logic [31:0] rsp_instr1;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_pc;
   logic [31:0] out_instr0;
   logic [31:0] out_instr1;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        halt;

   modport master (
      output req_valid, req_addr, out_valid, out_pc, out_instr0, out_instr1,
      input  req_ready, rsp_valid, rsp_instr0, rsp_instr1, out_ready,
             redirect_valid, redirect_pc, halt
   );

   modport slave (
      input  req_valid, req_addr, out_valid, out_pc, out_instr0, out_instr1,
      output req_ready, rsp_valid, rsp_instr0, rsp_instr1, out_ready,
             redirect_valid, redirect_pc, halt
   );
endinterface

// File: rtl/tinker_fetch_queue.sv
// Dual-issue fetch front end: credit-limited 8-byte fetch requests feeding an in-order pair queue.
// Optional macro FETCH_PERF_EN adds saturating perf_fetched/perf_dropped response counters.
module tinker_fetch_queue #(
   parameter int          DEPTH        = 4,
   parameter int          MAX_INFLIGHT = 2,
   parameter logic [63:0] RESET_PC     = 64'h2000
) (
   input  logic clk,
   input  logic reset,
   tinker_fetch_queue_if.master bus
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_dropped
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = $clog2(MAX_INFLIGHT + 1);

   logic [63:0]   r_fetchPc;
   logic [63:0]   r_respPc;
   logic [AW-1:0] r_rdPtr;
   logic [AW-1:0] r_wrPtr;
   logic [CW-1:0] r_count;
   logic [IW-1:0] r_inflight;
   logic [IW-1:0] r_drop;
   logic          r_skip0;
   logic [63:0]   r_pcMem [DEPTH];
   logic [31:0]   r_i0Mem [DEPTH];
   logic [31:0]   r_i1Mem [DEPTH];

   logic w_slotOk;
   logic w_creditOk;
   logic w_reqValid;
   logic w_reqFire;
   logic w_outValid;
   logic w_pop;
   logic w_dropRsp;
   logic w_push;

   // Counting queued plus outstanding entries guarantees every response has a free slot.
   assign w_slotOk   = 32'(r_inflight) < 32'(MAX_INFLIGHT);
   assign w_creditOk = (32'(r_count) + 32'(r_inflight)) < 32'(DEPTH);
   assign w_reqValid = reset & ~bus.halt & ~bus.redirect_valid & w_slotOk & w_creditOk;
   assign w_reqFire  = w_reqValid & bus.req_ready;
   assign w_outValid = (r_count != '0);
   assign w_pop      = w_outValid & bus.out_ready;
   assign w_dropRsp  = bus.rsp_valid & (r_drop != '0);
   assign w_push     = bus.rsp_valid & (r_drop == '0) & ~bus.redirect_valid;

   assign bus.req_valid  = w_reqValid;
   assign bus.req_addr   = r_fetchPc;
   assign bus.out_valid  = w_outValid;
   assign bus.out_pc     = w_outValid ? r_pcMem[r_rdPtr] : '0;
   assign bus.out_instr0 = w_outValid ? r_i0Mem[r_rdPtr] : '0;
   assign bus.out_instr1 = w_outValid ? r_i1Mem[r_rdPtr] : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fetchPc  <= RESET_PC;
         r_respPc   <= RESET_PC;
         r_rdPtr    <= '0;
         r_wrPtr    <= '0;
         r_count    <= '0;
         r_inflight <= '0;
         r_drop     <= '0;
         r_skip0    <= 1'b0;
      end else if (bus.redirect_valid) begin
         // A response landing in the redirect cycle is discarded here, so it is not owed later.
         r_rdPtr    <= '0;
         r_wrPtr    <= '0;
         r_count    <= '0;
         r_inflight <= r_inflight - IW'(bus.rsp_valid);
         r_drop     <= r_inflight - IW'(bus.rsp_valid);
         r_fetchPc  <= bus.redirect_pc & ~64'h7;
         r_respPc   <= bus.redirect_pc & ~64'h7;
         r_skip0    <= bus.redirect_pc[2];
      end else begin
         if (w_reqFire) begin
            r_fetchPc <= r_fetchPc + 64'd8;
         end
         r_inflight <= r_inflight + IW'(w_reqFire) - IW'(bus.rsp_valid);
         if (w_dropRsp) begin
            r_drop <= r_drop - IW'(1);
         end
         if (w_push) begin
            r_wrPtr  <= r_wrPtr + AW'(1);
            r_respPc <= r_respPc + 64'd8;
            r_skip0  <= 1'b0;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + AW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // Slot 0 of a pair entered mid-way through a redirect target becomes a bubble.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pcMem[r_wrPtr] <= r_respPc;
         r_i0Mem[r_wrPtr] <= r_skip0 ? 32'h0 : bus.rsp_instr0;
         r_i1Mem[r_wrPtr] <= bus.rsp_instr1;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] r_perfFetched;
   logic [31:0] r_perfDropped;
   logic        w_rspDiscard;

   assign w_rspDiscard = bus.rsp_valid & (bus.redirect_valid | (r_drop != '0));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_perfFetched <= '0;
         r_perfDropped <= '0;
      end else begin
         if (w_push && (r_perfFetched != 32'hFFFF_FFFF)) begin
            r_perfFetched <= r_perfFetched + 32'd1;
         end
         if (w_rspDiscard && (r_perfDropped != 32'hFFFF_FFFF)) begin
            r_perfDropped <= r_perfDropped + 32'd1;
         end
      end
   end

   assign perf_fetched = r_perfFetched;
   assign perf_dropped = r_perfDropped;
`endif

endmodule
